// File: rtl/noc_flit_pkg.sv
// Shared flit-level definitions for the router port arbitration protocol.
// Contents: flit_id encodings, advertised-length width, requester state
// enum and a saturating helper for the advertised hold length.
package noc_flit_pkg;

    localparam int LEN_W = 12;

    localparam logic [2:0] IDLE_ID = 3'b000;
    localparam logic [2:0] HEADER  = 3'b001;
    localparam logic [2:0] BODY    = 3'b010;
    localparam logic [2:0] TAIL    = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SEND,
        RETRY
    } state_t;

    // Clamp a cycle count to the largest value the length field can carry.
    function automatic logic [LEN_W-1:0] sat_len(input logic [31:0] v);
        logic [LEN_W-1:0] r;
        if (v > 32'((2 ** LEN_W) - 1)) r = '1;
        else                           r = v[LEN_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/flit_requester_if.sv
// Bundle of the requester's source-side and arbiter/crossbar-side signals.
//   master : the requester (consumes src_* and grant, drives the rest)
//   slave  : the environment (local source + arbiter + crossbar)
// Signals: src_valid/src_ready/src_data/src_last (source flit handshake),
//          grant/req/flit_id/length (arbitration), flit_valid/flit_data
//          (outgoing flit), err_trunc (truncation pulse).
interface flit_requester_if
    import noc_flit_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic              src_valid;
    logic              src_ready;
    logic [DATA_W-1:0] src_data;
    logic              src_last;
    logic              grant;
    logic              req;
    logic [2:0]        flit_id;
    logic [LEN_W-1:0]  length;
    logic              flit_valid;
    logic [DATA_W-1:0] flit_data;
    logic              err_trunc;

    modport master (
        input  src_valid, src_data, src_last, grant,
        output src_ready, req, flit_id, length, flit_valid, flit_data, err_trunc
    );

    modport slave (
        output src_valid, src_data, src_last, grant,
        input  src_ready, req, flit_id, length, flit_valid, flit_data, err_trunc
    );
endinterface

// File: rtl/flit_buf.sv
// Packet buffer: DEPTH x DATA_W register array, synchronous write,
// combinational read.
// Ports: clk, we/waddr/wdata (write side), raddr/rdata (read side).
module flit_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/flit_requester.sv
// Requester side of the router port arbitration protocol (one per input port).
// Buffers one packet from the local source, requests the port arbiter with a
// HEADER carrying the hold length, streams the packet while granted, and
// re-requests with the remaining length after a mid-packet timeout.
// Ports: clk, rst (synchronous, active-high), bus (flit_requester_if.master).
// Optional: define FLIT_REQUESTER_STATS_EN to add pkt_count[15:0] (transferred
// TAIL flits) and preempt_count[15:0] (SEND->RETRY transitions).
module flit_requester
    import noc_flit_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_FLITS = 16,
    parameter int SLACK     = 2
) (
    input  logic               clk,
    input  logic               rst,
    flit_requester_if.master   bus
`ifdef FLIT_REQUESTER_STATS_EN
    ,
    output logic [15:0]        pkt_count,
    output logic [15:0]        preempt_count
`endif
);
    localparam int PTR_W = $clog2(MAX_FLITS);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_FLITS - 1);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    state_t            state_reg, state_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  pkt_len_reg, pkt_len_next;
    logic              err_trunc_reg, err_trunc_next;
    logic              buf_we;
    logic              is_tail;
    logic [CNT_W-1:0]  remaining;
    logic [DATA_W-1:0] rd_data;

    flit_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_FLITS)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_ptr_reg),
        .wdata (bus.src_data),
        .raddr (rd_ptr_reg[PTR_W-1:0]),
        .rdata (rd_data)
    );

    assign is_tail   = (rd_ptr_reg == pkt_len_reg - ONE_C);
    assign remaining = pkt_len_reg - rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            pkt_len_reg   <= '0;
            err_trunc_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            pkt_len_reg   <= pkt_len_next;
            err_trunc_reg <= err_trunc_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        pkt_len_next   = pkt_len_reg;
        err_trunc_next = 1'b0;
        buf_we         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.src_valid) begin
                    buf_we      = 1'b1;
                    wr_ptr_next = wr_ptr_reg + PTR_W'(1);
                    // The last buffer slot closes the packet even without
                    // src_last; that case is flagged as a truncation.
                    if (bus.src_last || wr_ptr_reg == LAST_PTR) begin
                        pkt_len_next   = CNT_W'(wr_ptr_reg) + ONE_C;
                        state_next     = REQ;
                        err_trunc_next = !bus.src_last;
                    end
                end
            end
            REQ: begin
                if (bus.grant) state_next = SEND;
            end
            SEND: begin
                if (bus.grant) begin
                    if (is_tail) begin
                        state_next   = IDLE;
                        wr_ptr_next  = '0;
                        rd_ptr_next  = '0;
                        pkt_len_next = '0;
                    end else begin
                        rd_ptr_next = rd_ptr_reg + ONE_C;
                    end
                end else begin
                    // Timed out or preempted: rd_ptr holds so nothing is lost.
                    state_next = RETRY;
                end
            end
            RETRY: begin
                state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.flit_id = IDLE_ID;
        bus.length  = '0;
        case (state_reg)
            REQ: begin
                bus.flit_id = HEADER;
                bus.length  = sat_len(32'(remaining) + 32'(SLACK));
            end
            SEND:    bus.flit_id = is_tail ? TAIL : BODY;
            default: bus.flit_id = IDLE_ID;
        endcase
    end

    assign bus.src_ready  = (state_reg == IDLE);
    assign bus.req        = (state_reg == REQ) || (state_reg == SEND);
    // Only the valid strobe follows grant combinationally.
    assign bus.flit_valid = (state_reg == SEND) && bus.grant;
    assign bus.flit_data  = rd_data;
    assign bus.err_trunc  = err_trunc_reg;

`ifdef FLIT_REQUESTER_STATS_EN
    logic [15:0] pkt_count_reg;
    logic [15:0] preempt_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_reg     <= '0;
            preempt_count_reg <= '0;
        end else if (state_reg == SEND) begin
            if (bus.grant && is_tail) pkt_count_reg     <= pkt_count_reg + 16'd1;
            if (!bus.grant)           preempt_count_reg <= preempt_count_reg + 16'd1;
        end
    end

    assign pkt_count     = pkt_count_reg;
    assign preempt_count = preempt_count_reg;
`endif

endmodule
